// File: rtl/lpc_dma_pkg.sv
// Shared types and widths for the LPC DMA sequencer: FSM states, bus widths,
// and small helpers for channel-index width and chunk sizing.
package lpc_dma_pkg;

    localparam int ADDR_W             = 32;
    localparam int LEN_W              = 32;
    localparam int DEFAULT_DATA_BYTES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // A single-channel build still needs a 1-bit channel field.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [LEN_W-1:0] chunk_len(input logic [LEN_W-1:0] remaining,
                                                   input logic [LEN_W-1:0] max_chunk);
        return (remaining > max_chunk) ? max_chunk : remaining;
    endfunction

endpackage

// File: rtl/lpc_dma_sequencer_if.sv
// Command handshake plus read/write master control bundle.
// slave = sequencer view, master = command source and the two stream masters.
interface lpc_dma_sequencer_if
    import lpc_dma_pkg::*;
#(
    parameter int NUM_CH = 2
) ();

    localparam int CH_W = ch_width(NUM_CH);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;

    logic              rm_fixed_location;
    logic [ADDR_W-1:0] rm_read_base;
    logic [LEN_W-1:0]  rm_read_length;
    logic              rm_go;
    logic              rm_done;

    logic              wm_fixed_location;
    logic [ADDR_W-1:0] wm_write_base;
    logic [LEN_W-1:0]  wm_write_length;
    logic              wm_go;
    logic              wm_done;

    modport slave (
        input  cmd_valid, cmd_ch, cmd_src, cmd_dst, cmd_len, rm_done, wm_done,
        output cmd_ready,
        output rm_fixed_location, rm_read_base, rm_read_length, rm_go,
        output wm_fixed_location, wm_write_base, wm_write_length, wm_go
    );

    modport master (
        output cmd_valid, cmd_ch, cmd_src, cmd_dst, cmd_len, rm_done, wm_done,
        input  cmd_ready,
        input  rm_fixed_location, rm_read_base, rm_read_length, rm_go,
        input  wm_fixed_location, wm_write_base, wm_write_length, wm_go
    );

endinterface

// File: rtl/lpc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from NUM_CH requests, searching from the
// channel after the last accepted grant.
module lpc_rr_arbiter
    import lpc_dma_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_accept,
    output logic [NUM_CH-1:0] o_grant
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   w_ptr_next;
    logic [NUM_CH-1:0] w_mask;
    logic [NUM_CH-1:0] w_req_hi;
    logic [NUM_CH-1:0] w_gnt_hi;
    logic [NUM_CH-1:0] w_gnt_lo;

    // Requests at or above the pointer win; otherwise wrap to the lowest one.
    assign w_mask   = ~((NUM_CH'(1) << r_ptr) - NUM_CH'(1));
    assign w_req_hi = i_req & w_mask;

    always_comb begin
        w_gnt_hi = '0;
        w_gnt_lo = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_gnt_hi    = '0;
                w_gnt_hi[i] = 1'b1;
            end
            if (i_req[i]) begin
                w_gnt_lo    = '0;
                w_gnt_lo[i] = 1'b1;
            end
        end
    end

    assign o_grant = (|w_req_hi) ? w_gnt_hi : w_gnt_lo;

    always_comb begin
        w_ptr_next = r_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (o_grant[i]) begin
                w_ptr_next = CH_W'((i + 1) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/lpc_dma_sequencer.sv
// Multi-channel DMA sequencer: splits queued copy commands into MAX_CHUNK
// pieces and interleaves channels chunk by chunk on one read/write master pair.
module lpc_dma_sequencer
    import lpc_dma_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int MAX_CHUNK  = 1024,
    parameter int DATA_BYTES = DEFAULT_DATA_BYTES
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    lpc_dma_sequencer_if.slave     bus,
    output logic                   algorithm_run,
    output logic                   busy,
    output logic [NUM_CH-1:0]      ch_done,
    output logic                   cmd_err
);

    localparam int               CH_W        = ch_width(NUM_CH);
    localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);
    localparam logic [LEN_W-1:0] ALIGN_MASK  = LEN_W'(DATA_BYTES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [NUM_CH-1:0] r_pending;
    logic [ADDR_W-1:0] r_src [NUM_CH];
    logic [ADDR_W-1:0] r_dst [NUM_CH];
    logic [LEN_W-1:0]  r_rem [NUM_CH];
    logic [CH_W-1:0]   r_ch;
    logic              r_rm_flag;
    logic              r_wm_flag;
    logic [ADDR_W-1:0] r_rd_base;
    logic [ADDR_W-1:0] r_wr_base;
    logic [LEN_W-1:0]  r_chunk;
    logic              r_cmd_err;

    logic [NUM_CH-1:0] w_cmd_hit;
    logic [NUM_CH-1:0] w_upd;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_grant_idx;
    logic [ADDR_W-1:0] w_sel_src;
    logic [ADDR_W-1:0] w_sel_dst;
    logic [LEN_W-1:0]  w_sel_rem;
    logic              w_accept;
    logic              w_bad;
    logic              w_load;
    logic              w_last;
    logic              w_arb_accept;
    logic              w_go;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_cmd_hit[gi] = (bus.cmd_ch == CH_W'(gi));
            assign w_upd[gi]     = (r_state == ST_UPDATE) && (r_ch == CH_W'(gi));
            assign ch_done[gi]   = w_upd[gi] && w_last;
        end
    endgenerate

    // An out-of-range channel number matches no slot and is simply never ready.
    assign bus.cmd_ready = |(w_cmd_hit & ~r_pending);
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_bad         = (bus.cmd_len == '0)
                         || (|(bus.cmd_src & ALIGN_MASK))
                         || (|(bus.cmd_dst & ALIGN_MASK))
                         || (|(bus.cmd_len & ALIGN_MASK));
    assign w_load        = w_accept && !w_bad;
    assign w_last        = (r_rem[r_ch] == r_chunk);
    assign w_arb_accept  = (r_state == ST_IDLE) && (|r_pending);

    lpc_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .i_req    (r_pending),
        .i_accept (w_arb_accept),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_sel_src   = '0;
        w_sel_dst   = '0;
        w_sel_rem   = '0;
        w_grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_sel_src   = r_src[i];
                w_sel_dst   = r_dst[i];
                w_sel_rem   = r_rem[i];
                w_grant_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_go          = 1'b0;
        algorithm_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_go          = 1'b1;
                algorithm_run = 1'b1;
                w_state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                algorithm_run = 1'b1;
                if (r_rm_flag && r_wm_flag) begin
                    w_state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_rm_flag <= 1'b0;
            r_wm_flag <= 1'b0;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_chunk   <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cmd_err <= w_accept && w_bad;
            // Bases and length are captured on grant so they hold through WAIT.
            if (w_arb_accept) begin
                r_ch      <= w_grant_idx;
                r_rd_base <= w_sel_src;
                r_wr_base <= w_sel_dst;
                r_chunk   <= chunk_len(w_sel_rem, MAX_CHUNK_L);
            end
            if (r_state == ST_WAIT) begin
                r_rm_flag <= r_rm_flag | bus.rm_done;
                r_wm_flag <= r_wm_flag | bus.wm_done;
            end else if (r_state == ST_UPDATE) begin
                r_rm_flag <= 1'b0;
                r_wm_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_load && w_cmd_hit[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_upd[i] && w_last) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Channel context needs no reset: it is only read while the channel is pending.
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_load && w_cmd_hit[i]) begin
                r_src[i] <= bus.cmd_src;
                r_dst[i] <= bus.cmd_dst;
                r_rem[i] <= bus.cmd_len;
            end else if (w_upd[i]) begin
                r_src[i] <= r_src[i] + r_chunk;
                r_dst[i] <= r_dst[i] + r_chunk;
                r_rem[i] <= r_rem[i] - r_chunk;
            end
        end
    end

    assign bus.rm_fixed_location = 1'b0;
    assign bus.wm_fixed_location = 1'b0;
    assign bus.rm_read_base      = r_rd_base;
    assign bus.wm_write_base     = r_wr_base;
    assign bus.rm_read_length    = r_chunk;
    assign bus.wm_write_length   = r_chunk;
    assign bus.rm_go             = w_go;
    assign bus.wm_go             = w_go;
    assign busy                  = (|r_pending) || (r_state != ST_IDLE);
    assign cmd_err               = r_cmd_err;

endmodule

// File: tb/tb_lpc_dma_sequencer.sv
// Directed bench for lpc_dma_sequencer: plays command source and both stream
// masters, checking chunk bases/lengths, completion pulses and reset behaviour.
module tb_lpc_dma_sequencer;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       algorithm_run;
    logic       busy;
    logic [1:0] ch_done;
    logic       cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    lpc_dma_sequencer_if #(.NUM_CH(2)) bus ();

    lpc_dma_sequencer #(
        .NUM_CH     (2),
        .MAX_CHUNK  (1024),
        .DATA_BYTES (2)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .bus           (bus),
        .algorithm_run (algorithm_run),
        .busy          (busy),
        .ch_done       (ch_done),
        .cmd_err       (cmd_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input int ch, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input bit exp_err);
        int gos;
        bus.cmd_ch  = ch[0];
        bus.cmd_src = src;
        bus.cmd_dst = dst;
        bus.cmd_len = len;
        #1;
        check("cmd_ready_before", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        @(negedge clk_clk);
        bus.cmd_valid = 1'b0;
        check("cmd_err_pulse", {31'd0, cmd_err}, {31'd0, exp_err});
        $display("cmd ch=%0d src=0x%08h dst=0x%08h len=%0d err=%0b", ch, src, dst, len, cmd_err);
        if (exp_err) begin
            @(negedge clk_clk);
            check("cmd_err_cleared", {31'd0, cmd_err}, 32'd0);
            check("cmd_ready_after_err", {31'd0, bus.cmd_ready}, 32'd1);
            gos = 0;
            for (int k = 0; k < 5; k++) begin
                if (bus.rm_go) gos++;
                @(negedge clk_clk);
            end
            check("no_go_after_err", gos, 0);
            check("busy_after_err", {31'd0, busy}, 32'd0);
        end else begin
            check("cmd_ready_pending", {31'd0, bus.cmd_ready}, 32'd0);
        end
    endtask

    task automatic wait_go();
        int waited;
        waited = 0;
        while (!bus.rm_go && waited < 40) begin
            @(negedge clk_clk);
            waited++;
        end
        check("go_seen", {31'd0, bus.rm_go}, 32'd1);
    endtask

    task automatic do_chunk(input int ch, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input int rm_dly, input int wm_dly,
                            input bit last);
        int maxd;
        wait_go();
        if (!bus.rm_go) return;
        check("wm_go", {31'd0, bus.wm_go}, 32'd1);
        check("rd_base", bus.rm_read_base, src);
        check("wr_base", bus.wm_write_base, dst);
        check("rd_len", bus.rm_read_length, len);
        check("wr_len", bus.wm_write_length, len);
        check("run_issue", {31'd0, algorithm_run}, 32'd1);
        $display("chunk ch=%0d rd=0x%08h wr=0x%08h len=%0d last=%0b",
                 ch, bus.rm_read_base, bus.wm_write_base, bus.rm_read_length, last);
        @(negedge clk_clk);
        check("go_one_cycle", {30'd0, bus.rm_go, bus.wm_go}, 32'd0);
        maxd = (rm_dly > wm_dly) ? rm_dly : wm_dly;
        for (int t = 0; t <= maxd; t++) begin
            bus.rm_done = (t == rm_dly);
            bus.wm_done = (t == wm_dly);
            @(negedge clk_clk);
            check("run_wait", {31'd0, algorithm_run}, 32'd1);
            check("base_stable", bus.rm_read_base, src);
        end
        bus.rm_done = 1'b0;
        bus.wm_done = 1'b0;
        @(negedge clk_clk);
        check("run_update", {31'd0, algorithm_run}, 32'd0);
        check("ch_done_update", {30'd0, ch_done}, last ? (32'd1 << ch) : 32'd0);
        @(negedge clk_clk);
        check("ch_done_idle", {30'd0, ch_done}, 32'd0);
    endtask

    initial begin
        int gos;
        reset_reset   = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.rm_done   = 1'b0;
        bus.wm_done   = 1'b0;
        repeat (2) @(negedge clk_clk);

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_run", {31'd0, algorithm_run}, 32'd0);
        check("rst_go", {30'd0, bus.rm_go, bus.wm_go}, 32'd0);
        check("rst_rd_base", bus.rm_read_base, 32'd0);
        check("rst_rd_len", bus.rm_read_length, 32'd0);
        check("rst_ch_done", {30'd0, ch_done}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("fixed_loc", {30'd0, bus.rm_fixed_location, bus.wm_fixed_location}, 32'd0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

        // Single channel, 2500 bytes -> 1024 + 1024 + 452
        send_cmd(0, 32'h0000_1000, 32'h0000_8000, 32'd2500, 1'b0);
        check("busy_pending", {31'd0, busy}, 32'd1);
        do_chunk(0, 32'h0000_1000, 32'h0000_8000, 32'd1024, 0, 0, 1'b0);
        do_chunk(0, 32'h0000_1400, 32'h0000_8400, 32'd1024, 2, 1, 1'b0);
        do_chunk(0, 32'h0000_1800, 32'h0000_8800, 32'd452, 1, 3, 1'b1);
        check("busy_done", {31'd0, busy}, 32'd0);

        // Two channels interleave per chunk; wm before rm, then same-cycle done
        send_cmd(0, 32'h0000_2000, 32'h0000_9000, 32'd2048, 1'b0);
        send_cmd(1, 32'h0000_4000, 32'h0000_A000, 32'd2048, 1'b0);
        do_chunk(0, 32'h0000_2000, 32'h0000_9000, 32'd1024, 5, 0, 1'b0);
        do_chunk(1, 32'h0000_4000, 32'h0000_A000, 32'd1024, 2, 2, 1'b0);
        do_chunk(0, 32'h0000_2400, 32'h0000_9400, 32'd1024, 0, 3, 1'b1);
        do_chunk(1, 32'h0000_4400, 32'h0000_A400, 32'd1024, 1, 1, 1'b1);
        check("busy_two_done", {31'd0, busy}, 32'd0);

        // Rejected commands
        send_cmd(0, 32'h0000_1000, 32'h0000_2000, 32'd3, 1'b1);
        send_cmd(0, 32'h0000_1000, 32'h0000_2000, 32'd0, 1'b1);
        send_cmd(1, 32'h0000_1000, 32'h0000_8001, 32'd4, 1'b1);

        // Source address wraps past 2^32
        send_cmd(1, 32'hFFFF_FC00, 32'h0000_0100, 32'd2048, 1'b0);
        do_chunk(1, 32'hFFFF_FC00, 32'h0000_0100, 32'd1024, 0, 0, 1'b0);
        do_chunk(1, 32'h0000_0000, 32'h0000_0500, 32'd1024, 0, 0, 1'b1);

        // Reset while waiting on the masters
        send_cmd(0, 32'h0000_3000, 32'h0000_5000, 32'd4096, 1'b0);
        wait_go();
        @(negedge clk_clk);
        bus.wm_done = 1'b1;
        @(negedge clk_clk);
        bus.wm_done = 1'b0;
        #2;
        reset_reset = 1'b1;
        #1;
        check("arst_run", {31'd0, algorithm_run}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_go", {30'd0, bus.rm_go, bus.wm_go}, 32'd0);
        check("arst_base", bus.rm_read_base, 32'd0);
        check("arst_len", bus.wm_write_length, 32'd0);
        check("arst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        gos = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_clk);
            if (bus.rm_go || (ch_done != 2'b00) || busy) gos++;
        end
        check("arst_quiet", gos, 0);
        $display("reset mid-transfer: queued work dropped");

        // Stale wm flag must not survive reset: rm first, wm 3 cycles later
        send_cmd(0, 32'h0000_0100, 32'h0000_0200, 32'd1024, 1'b0);
        do_chunk(0, 32'h0000_0100, 32'h0000_0200, 32'd1024, 0, 3, 1'b1);
        check("busy_final", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lpc_dma_sequencer.md
LPC_DMA_SEQUENCER -- requirements
Module: lpc_dma_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent command channels (1..8).
REQ-002 SHALL have parameter MAX_CHUNK, default 1024, meaning the maximum bytes per master transfer (power of two, >= DATA_BYTES).
REQ-003 SHALL have parameter DATA_BYTES, default 2, meaning the stream word size in bytes (16-bit masters).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk_clk, input, 1, the single clock.
REQ-006 SHALL have port reset_reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_ch in clog2(NUM_CH), cmd_src in 32, cmd_dst in 32, cmd_len in 32, forming the command handshake.
REQ-008 SHALL have ports rm_fixed_location out 1, rm_read_base out 32, rm_read_length out 32, rm_go out 1, rm_done in 1, forming the read-master control.
REQ-009 SHALL have ports wm_fixed_location out 1, wm_write_base out 32, wm_write_length out 32, wm_go out 1, wm_done in 1, forming the write-master control.
REQ-010 SHALL have ports algorithm_run out 1 (chunk in flight), busy out 1, ch_done out NUM_CH (per-channel completion pulses), and cmd_err out 1 (rejected-command pulse).

Function
REQ-011 SHALL accept a command on clock edge with cmd_valid && cmd_ready; cmd_ready = !pending[cmd_ch].
REQ-012 SHALL, on accepting a command with cmd_len==0 or any of src/dst/len not a multiple of DATA_BYTES, pulse cmd_err for 1 cycle and leave the channel not pending.
REQ-013 SHALL otherwise store src, dst and remaining=len per channel and set pending[ch].
REQ-014 SHALL have states IDLE, ISSUE, WAIT, UPDATE.
REQ-015 IDLE: if any channel is pending, SHALL grant it via round-robin starting after the last grant and go to ISSUE; else stay.
REQ-016 ISSUE: SHALL drive base = channel src/dst and length = min(remaining, MAX_CHUNK), pulse rm_go and wm_go high for exactly one cycle, then go to WAIT.
REQ-017 Base/length outputs SHALL stay stable from ISSUE through the end of WAIT.
REQ-018 WAIT: SHALL latch rm_done and wm_done into sticky flags (either order, or the same cycle) and go to UPDATE in the cycle after both flags are set.
REQ-019 UPDATE: SHALL add chunk to src and dst, subtract chunk from remaining, and clear the sticky flags.
REQ-020 UPDATE: if the new remaining==0, SHALL pulse ch_done[ch] for 1 cycle and clear pending[ch]; then go to IDLE in all cases, so that channels interleave per chunk.
REQ-021 Address arithmetic SHALL be 32-bit modulo 2^32; wrap-around is permitted and not flagged.
REQ-022 A new command on a non-granted channel SHALL be accepted in any state; the granted channel's cmd_ready SHALL stay low until its ch_done.
REQ-023 algorithm_run SHALL be high in ISSUE and WAIT. busy SHALL be high when any channel is pending or state != IDLE.
REQ-024 rm_fixed_location and wm_fixed_location SHALL be constant 0.
REQ-025 rm_done/wm_done asserted outside WAIT SHALL be ignored.

Reset
REQ-026 On reset_reset SHALL force state=IDLE, all pending=0, sticky flags=0, RR pointer=0, go/ch_done/cmd_err/algorithm_run/busy=0, and base/length=0.
REQ-027 Reset mid-transfer SHALL drop all queued work without completion pulses; aborting the masters is the system's responsibility.

Structure
REQ-028 Package lpc_dma_pkg SHALL hold the state enum, the DATA_BYTES default and the address/length width constants.
REQ-029 Round-robin selection SHALL be sub-module lpc_rr_arbiter (NUM_CH requests in, one-hot grant out, pointer advances on accept).

Verification
REQ-030 Ch0 src=0x1000 dst=0x8000 len=2500 -> 3 chunks (1024, 1024, 452), bases 0x1000/0x1400/0x1800, one ch_done[0] pulse.
REQ-031 Ch0 and ch1 both len=2048 -> grants alternate 0,1,0,1, with both ch_done after 4 chunks.
REQ-032 wm_done arrives 5 cycles before rm_done, then the same-cycle case -> UPDATE exactly once per chunk, with no lost or double chunk.
REQ-033 len=3 or len=0 -> cmd_err pulse, no rm_go, and the channel stays ready.
REQ-034 src=0xFFFFFC00 len=2048 -> second chunk base 0x00000000.
REQ-035 reset_reset asserted in WAIT -> outputs 0 immediately, no ch_done, busy=0.
